// File: rtl/tea_pkg.sv
// Shared definitions for the iterative TEA engine.
//   tea_word_t / tea_block_t / tea_key_t : 32/64/128-bit datapath types
//   TEA_DELTA                            : key-schedule constant
//   TEA_ENC / TEA_DEC                    : mode encoding on the mode input
//   tea_state_t                          : core sequencer states
//   tea_dec_sum()                        : starting sum for decryption
package tea_pkg;

  typedef logic [31:0]  tea_word_t;
  typedef logic [63:0]  tea_block_t;
  typedef logic [127:0] tea_key_t;

  localparam tea_word_t TEA_DELTA = 32'h9E3779B9;

  localparam logic TEA_ENC = 1'b0;
  localparam logic TEA_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } tea_state_t;

  // Decryption walks the sum backwards from DELTA*ROUNDS (mod 2^32).
  function automatic tea_word_t tea_dec_sum(input tea_word_t delta,
                                            input int unsigned rounds);
    logic [63:0] prod;
    prod = 64'(delta) * 64'(rounds);
    return prod[31:0];
  endfunction

endpackage

// File: rtl/tea_iter_core_if.sv
// Block/handshake bundle for tea_iter_core.
//   in_valid/in_ready   : input handshake; mode, data_in, key ride with it
//   out_valid/out_ready : output handshake; data_out rides with it
//   busy                : core is in RUN or DONE
// slave modport is the core side, master modport is the controller side.
interface tea_iter_core_if;
  import tea_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       mode;
  tea_block_t data_in;
  tea_key_t   key;
  logic       out_valid;
  logic       out_ready;
  tea_block_t data_out;
  logic       busy;

  modport slave (
    input  in_valid, mode, data_in, key, out_ready,
    output in_ready, out_valid, data_out, busy
  );

  modport master (
    output in_valid, mode, data_in, key, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/tea_round.sv
// One combinational TEA round (encrypt or decrypt).
//   v0, v1, sum       : state entering the round
//   key               : {k0, k1, k2, k3}, k0 in the top word
//   mode              : TEA_ENC / TEA_DEC
//   v0_nxt, v1_nxt,
//   sum_nxt           : state leaving the round
module tea_round import tea_pkg::*; #(
  parameter tea_word_t DELTA = TEA_DELTA
) (
  input  tea_word_t v0,
  input  tea_word_t v1,
  input  tea_word_t sum,
  input  tea_key_t  key,
  input  logic      mode,
  output tea_word_t v0_nxt,
  output tea_word_t v1_nxt,
  output tea_word_t sum_nxt
);

  tea_word_t k0, k1, k2, k3;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];

  always_comb begin
    if (mode == TEA_ENC) begin
      sum_nxt = sum + DELTA;
      v0_nxt  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_nxt) ^ ((v1 >> 5) + k1));
      v1_nxt  = v1 + (((v0_nxt << 4) + k2) ^ (v0_nxt + sum_nxt) ^ ((v0_nxt >> 5) + k3));
    end else begin
      // Decrypt undoes the halves in reverse order with the pre-decrement sum.
      v1_nxt  = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
      v0_nxt  = v0 - (((v1_nxt << 4) + k0) ^ (v1_nxt + sum) ^ ((v1_nxt >> 5) + k1));
      sum_nxt = sum - DELTA;
    end
  end

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA engine: UNROLL rounds per clock, ROUNDS rounds per block.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : tea_iter_core_if.slave -- in_valid/in_ready with mode, data_in,
//          key; out_valid/out_ready with data_out; busy in RUN or DONE
// Block, key and mode are captured at accept; data_out holds until taken.
module tea_iter_core import tea_pkg::*; #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned UNROLL = 1,
  parameter tea_word_t   DELTA  = TEA_DELTA
) (
  input logic           clk,
  input logic           rst,
  tea_iter_core_if.slave bus
);

  localparam int unsigned CW      = $clog2(ROUNDS) + 1;
  localparam tea_word_t   DEC_SUM = tea_dec_sum(DELTA, ROUNDS);

  tea_state_t     st;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  tea_word_t      v0_q, v1_q, sum_q;
  tea_key_t       key_q;
  logic           mode_q;
  tea_block_t     data_out_q;
  logic           out_valid_q;
  logic           in_ready_q;
  logic           busy_q;

  tea_word_t cv0  [UNROLL+1];
  tea_word_t cv1  [UNROLL+1];
  tea_word_t csum [UNROLL+1];

  assign cv0[0]  = v0_q;
  assign cv1[0]  = v1_q;
  assign csum[0] = sum_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    tea_round #(.DELTA(DELTA)) u_round (
      .v0      (cv0[i]),
      .v1      (cv1[i]),
      .sum     (csum[i]),
      .key     (key_q),
      .mode    (mode_q),
      .v0_nxt  (cv0[i+1]),
      .v1_nxt  (cv1[i+1]),
      .sum_nxt (csum[i+1])
    );
  end

  assign cnt_nxt = cnt + CW'(UNROLL);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      cnt         <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      mode_q      <= TEA_ENC;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (bus.in_valid) begin
            v0_q       <= bus.data_in[63:32];
            v1_q       <= bus.data_in[31:0];
            key_q      <= bus.key;
            mode_q     <= bus.mode;
            sum_q      <= (bus.mode == TEA_DEC) ? DEC_SUM : '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            st         <= ST_RUN;
          end
        end
        ST_RUN: begin
          v0_q  <= cv0[UNROLL];
          v1_q  <= cv1[UNROLL];
          sum_q <= csum[UNROLL];
          cnt   <= cnt_nxt;
          if (cnt_nxt == CW'(ROUNDS)) begin
            data_out_q  <= {cv0[UNROLL], cv1[UNROLL]};
            out_valid_q <= 1'b1;
            st          <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            st          <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tea_iter_core.sv
// Bench for tea_iter_core: three instances (UNROLL 1, 4, 32) share stimulus;
// a per-instance scoreboard checks every result and its latency.
module tb_tea_iter_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         mode;
  logic [63:0]  data_in;
  logic [127:0] key;
  logic         out_ready;

  always #5 clk = ~clk;

  tea_iter_core_if if1 ();
  tea_iter_core_if if4 ();
  tea_iter_core_if if32 ();

  assign if1.in_valid  = in_valid;  assign if4.in_valid  = in_valid;  assign if32.in_valid  = in_valid;
  assign if1.mode      = mode;      assign if4.mode      = mode;      assign if32.mode      = mode;
  assign if1.data_in   = data_in;   assign if4.data_in   = data_in;   assign if32.data_in   = data_in;
  assign if1.key       = key;       assign if4.key       = key;       assign if32.key       = key;
  assign if1.out_ready = out_ready; assign if4.out_ready = out_ready; assign if32.out_ready = out_ready;

  tea_iter_core #(.ROUNDS(32), .UNROLL(1),  .DELTA(32'h9E3779B9)) dut1  (.clk(clk), .rst(rst), .bus(if1));
  tea_iter_core #(.ROUNDS(32), .UNROLL(4),  .DELTA(32'h9E3779B9)) dut4  (.clk(clk), .rst(rst), .bus(if4));
  tea_iter_core #(.ROUNDS(32), .UNROLL(32), .DELTA(32'h9E3779B9)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  logic        ov  [3];
  logic        ir  [3];
  logic        bsy [3];
  logic [63:0] dout[3];

  assign ov[0] = if1.out_valid; assign ov[1] = if4.out_valid; assign ov[2] = if32.out_valid;
  assign ir[0] = if1.in_ready;  assign ir[1] = if4.in_ready;  assign ir[2] = if32.in_ready;
  assign bsy[0] = if1.busy;     assign bsy[1] = if4.busy;     assign bsy[2] = if32.busy;
  assign dout[0] = if1.data_out; assign dout[1] = if4.data_out; assign dout[2] = if32.data_out;

  localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat [3] = '{32, 8, 1};
  logic [63:0] sbq [3][$];
  int          acc_cyc [3];
  logic        pend [3];
  logic        prev_ov [3];
  int          accepts [3] = '{0, 0, 0};
  int          outs [3] = '{0, 0, 0};
  logic [63:0] last_out [3];

  typedef struct {
    logic         m;
    logic [127:0] k;
    logic [63:0]  d;
    logic [63:0]  exp;
  } vec_t;

  vec_t vt [6];

  function automatic logic [63:0] tea_model(input logic m, input logic [127:0] k,
                                            input logic [63:0] d);
    logic [31:0] y, z, s, k0, k1, k2, k3;
    y = d[63:32]; z = d[31:0];
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    if (!m) begin
      s = 32'h0;
      for (int i = 0; i < 32; i++) begin
        s = s + 32'h9E3779B9;
        y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
      end
    end else begin
      s = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        s = s - 32'h9E3779B9;
      end
    end
    return {y, z};
  endfunction

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping on the values the coming edge will see,
  // then the edge, then a latency check on any fresh out_valid.
  task automatic tick();
    logic [63:0] e;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        sbq[k].delete();
        pend[k] = 1'b0;
      end else begin
        if (in_valid && ir[k]) begin
          sbq[k].push_back(tea_model(mode, key, data_in));
          acc_cyc[k] = cyc + 1;
          pend[k] = 1'b1;
          accepts[k]++;
        end
        if (ov[k] && out_ready) begin
          if (sbq[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_spurious[%0d]: data_out=%h with nothing expected", k, dout[k]);
          end else begin
            e = sbq[k].pop_front();
            check64($sformatf("sb_data[%0d]", k), dout[k], e);
          end
          last_out[k] = dout[k];
          outs[k]++;
        end
      end
      prev_ov[k] = ov[k];
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && !prev_ov[k]) begin
        if (!pend[k]) begin
          checks++; errors++;
          $display("FAIL out_valid_spurious[%0d]: out_valid=1 required 0", k);
        end else begin
          check64($sformatf("latency[%0d]", k), 64'(cyc - acc_cyc[k]), 64'(lat[k]));
          pend[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic accept_block(input logic m, input logic [127:0] k, input logic [63:0] d);
    int a0, g;
    mode = m; key = k; data_in = d; in_valid = 1'b1;
    a0 = accepts[0];
    g = 0;
    while (accepts[0] == a0 && g < 10) begin tick(); g++; end
    in_valid = 1'b0;
    if (accepts[0] == a0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", ir[0]);
    end
  endtask

  task automatic wait_out(input int n0);
    int g;
    g = 0;
    while (outs[0] == n0 && g < 100) begin tick(); g++; end
    if (outs[0] == n0) begin
      checks++; errors++;
      $display("FAIL output_timeout: out_valid=%0b required 1", ov[0]);
    end
  endtask

  task automatic run_block(input logic m, input logic [127:0] k, input logic [63:0] d,
                           output logic [63:0] res);
    int n0;
    n0 = outs[0];
    accept_block(m, k, d);
    wait_out(n0);
    tick();
    res = last_out[0];
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      check64($sformatf("%s in_ready[%0d]", tag, k), 64'(ir[k]), 64'd1);
      check64($sformatf("%s out_valid[%0d]", tag, k), 64'(ov[k]), 64'd0);
      check64($sformatf("%s busy[%0d]", tag, k), 64'(bsy[k]), 64'd0);
      check64($sformatf("%s data_out[%0d]", tag, k), dout[k], 64'd0);
    end
  endtask

  initial begin
    logic [63:0]  res, ct, pt, e;
    logic [127:0] rk;
    int           n0, g;
    logic         saw;

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; data_in = '0; key = '0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; prev_ov[i] = 1'b0; acc_cyc[i] = 0; end
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    vt[0] = '{m: 1'b0, k: '0, d: '0, exp: ZERO_CT};
    vt[1] = '{m: 1'b1, k: '0, d: ZERO_CT, exp: 64'h0};
    for (int i = 2; i < 6; i++) begin
      vt[i].m = 1'(i & 1);
      vt[i].k = {$urandom, $urandom, $urandom, $urandom};
      vt[i].d = {$urandom, $urandom};
      vt[i].exp = tea_model(vt[i].m, vt[i].k, vt[i].d);
    end
    vt[5].k = '1; vt[5].d = '1;
    vt[5].exp = tea_model(vt[5].m, vt[5].k, vt[5].d);

    for (int i = 0; i < 6; i++) begin
      run_block(vt[i].m, vt[i].k, vt[i].d, res);
      check64($sformatf("vec[%0d] u1", i), res, vt[i].exp);
      check64($sformatf("vec[%0d] u4", i), last_out[1], vt[i].exp);
      check64($sformatf("vec[%0d] u32", i), last_out[2], vt[i].exp);
    end

    // Backpressure: result must hold, new blocks must be refused.
    out_ready = 1'b0;
    rk = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom};
    e = tea_model(1'b0, rk, pt);
    accept_block(1'b0, rk, pt);
    g = 0;
    while (!ov[0] && g < 100) begin tick(); g++; end
    check64("bp out_valid up", 64'(ov[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; data_in = ~pt; mode = 1'b1; key = ~rk;
      tick();
      check64("bp data_hold", dout[0], e);
      check64("bp in_ready", 64'(ir[0]), 64'd0);
      check64("bp out_valid", 64'(ov[0]), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check64("bp release out_valid", 64'(ov[0]), 64'd0);
    check64("bp release in_ready", 64'(ir[0]), 64'd1);
    tick();

    // Reset in the middle of RUN abandons the block.
    accept_block(1'b0, rk, pt);
    repeat (9) tick();
    check64("mid busy", 64'(bsy[0]), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ov[0]) saw = 1'b1;
    end
    check64("abandoned no out_valid", 64'(saw), 64'd0);
    run_block(1'b0, '0, '0, res);
    check64("after reset vec0", res, ZERO_CT);

    // Key/mode/data ports toggle every RUN cycle; captured values must win.
    rk = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom};
    e = tea_model(1'b1, rk, pt);
    n0 = outs[0];
    accept_block(1'b1, rk, pt);
    g = 0;
    while (outs[0] == n0 && g < 100) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'($urandom);
      data_in = {$urandom, $urandom};
      tick();
      g++;
    end
    check64("port churn result", last_out[0], e);
    tick();

    // Round trip through encrypt then decrypt.
    for (int i = 0; i < 200; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      run_block(1'b0, rk, pt, ct);
      run_block(1'b1, rk, ct, res);
      check64($sformatf("roundtrip[%0d]", i), res, pt);
    end

    for (int k = 0; k < 3; k++)
      check64($sformatf("sb_drained[%0d]", k), 64'(sbq[k].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
